// File: rtl/fp_issue_sequencer.sv
// fp_issue_sequencer: issues one FP instruction at a time to a shared
// multi-cycle FP core. It holds the pipeline while the core works, abandons
// the op after a bounded wait, and presents a single write-back beat.
module fp_issue_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_fp,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_a,
    input  logic [31:0]      issue_b,
    input  logic [5:0]       issue_waddr,
    input  logic             issue_regwrite,
    output logic             core_start,
    output logic [3:0]       core_op,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    input  logic [31:0]      core_result,
    input  logic [2:0]       core_flag,
    input  logic             core_done,
    output logic             stall,
    output logic [5:0]       busy_waddr,
    output logic             busy,
    output logic             wb_valid,
    output logic [31:0]      wb_data,
    output logic [5:0]       wb_waddr,
    output logic             wb_regwrite,
    output logic             err_timeout,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] special_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [5:0]       waddr_q, waddr_d;
    logic             regwrite_q, regwrite_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [5:0]       wb_waddr_q, wb_waddr_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [CNT_W-1:0] special_count_q, special_count_d;

    logic finish_ok;
    logic finish_abort;

    // A completion is only honoured while the core is actually running; a
    // completion in the same cycle as the last wait cycle beats the timeout.
    always_comb begin
        finish_ok    = ((state_q == S_START) || (state_q == S_WAIT)) && core_done;
        finish_abort = (state_q == S_WAIT) && !core_done && (tmo_q == TMO_LAST);
    end

    // Next-state logic: latch the instruction on issue, run the timeout, and
    // build the registered write-back beat on the edge that enters DONE.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        waddr_d         = waddr_q;
        regwrite_d      = regwrite_q;
        tmo_d           = tmo_q;
        err_d           = err_q;
        wb_valid_d      = 1'b0;
        wb_data_d       = wb_data_q;
        wb_waddr_d      = wb_waddr_q;
        wb_regwrite_d   = 1'b0;
        op_count_d      = op_count_q;
        special_count_d = special_count_q;

        case (state_q)
            S_IDLE: begin
                if (issue_valid && issue_fp) begin
                    op_d       = issue_op;
                    a_d        = issue_a;
                    b_d        = issue_b;
                    waddr_d    = issue_waddr;
                    regwrite_d = issue_regwrite;
                    state_d    = S_START;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = core_done ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (finish_ok || finish_abort) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish_ok) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = core_result;
            wb_waddr_d    = waddr_q;
            wb_regwrite_d = regwrite_q && (core_flag == 3'b000);
            op_count_d    = op_count_q + CNT_W'(1);
            if ((core_flag != 3'b000) && (special_count_q != CNT_MAX)) begin
                special_count_d = special_count_q + CNT_W'(1);
            end
        end else if (finish_abort) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = '0;
            wb_waddr_d    = waddr_q;
            wb_regwrite_d = 1'b0;
            err_d         = 1'b1;
            op_count_d    = op_count_q + CNT_W'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            waddr_q         <= '0;
            regwrite_q      <= 1'b0;
            tmo_q           <= '0;
            err_q           <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_data_q       <= '0;
            wb_waddr_q      <= '0;
            wb_regwrite_q   <= 1'b0;
            op_count_q      <= '0;
            special_count_q <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            a_q             <= a_d;
            b_q             <= b_d;
            waddr_q         <= waddr_d;
            regwrite_q      <= regwrite_d;
            tmo_q           <= tmo_d;
            err_q           <= err_d;
            wb_valid_q      <= wb_valid_d;
            wb_data_q       <= wb_data_d;
            wb_waddr_q      <= wb_waddr_d;
            wb_regwrite_q   <= wb_regwrite_d;
            op_count_q      <= op_count_d;
            special_count_q <= special_count_d;
        end
    end

    // Stall covers the issue cycle through the last wait cycle; it is low in
    // DONE so ID/EX advances on the same edge the write-back is taken.
    always_comb begin
        stall = ((state_q == S_IDLE) && issue_valid && issue_fp)
              || (state_q == S_START) || (state_q == S_WAIT);
    end

    assign core_start    = (state_q == S_START);
    assign core_op       = op_q;
    assign core_a        = a_q;
    assign core_b        = b_q;
    assign busy          = (state_q != S_IDLE);
    assign busy_waddr    = waddr_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_waddr      = wb_waddr_q;
    assign wb_regwrite   = wb_regwrite_q;
    assign err_timeout   = err_q;
    assign op_count      = op_count_q;
    assign special_count = special_count_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Testbench for fp_issue_sequencer: a driver issues instructions and plays
// the FP core, a reference model predicts each write-back beat into a queue,
// and a monitor pops and compares whenever wb_valid is seen.
module tb_fp_issue_sequencer;

    localparam int TIMEOUT_CYCLES = 64;
    // Narrow counters so that wrap and saturation are reached in a short run.
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic             issue_fp;
    logic [3:0]       issue_op;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [5:0]       issue_waddr;
    logic             issue_regwrite;
    logic             core_start;
    logic [3:0]       core_op;
    logic [31:0]      core_a;
    logic [31:0]      core_b;
    logic [31:0]      core_result;
    logic [2:0]       core_flag;
    logic             core_done;
    logic             stall;
    logic [5:0]       busy_waddr;
    logic             busy;
    logic             wb_valid;
    logic [31:0]      wb_data;
    logic [5:0]       wb_waddr;
    logic             wb_regwrite;
    logic             err_timeout;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] special_count;

    fp_issue_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_fp      (issue_fp),
        .issue_op      (issue_op),
        .issue_a       (issue_a),
        .issue_b       (issue_b),
        .issue_waddr   (issue_waddr),
        .issue_regwrite(issue_regwrite),
        .core_start    (core_start),
        .core_op       (core_op),
        .core_a        (core_a),
        .core_b        (core_b),
        .core_result   (core_result),
        .core_flag     (core_flag),
        .core_done     (core_done),
        .stall         (stall),
        .busy_waddr    (busy_waddr),
        .busy          (busy),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_waddr      (wb_waddr),
        .wb_regwrite   (wb_regwrite),
        .err_timeout   (err_timeout),
        .op_count      (op_count),
        .special_count (special_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  waddr;
        int          lat;
        logic [31:0] res;
        logic [2:0]  flag;
    } core_beh_t;

    typedef struct {
        logic [31:0]      data;
        logic [5:0]       waddr;
        logic             regwrite;
        logic [CNT_W-1:0] opc;
        logic [CNT_W-1:0] spc;
        logic             err;
    } wb_exp_t;

    core_beh_t core_q[$];
    wb_exp_t   wb_q[$];

    int   n_vectors     = 0;
    int   n_miscompares = 0;
    int   model_ops     = 0;
    int   model_special = 0;
    logic model_err     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural FP core: on each start pulse take the next planned response
    // and raise core_done after the planned number of cycles (never if < 0).
    initial begin
        int        done_timer;
        core_beh_t cur;
        done_timer  = -1;
        core_done   = 1'b0;
        core_result = '0;
        core_flag   = '0;
        forever begin
            @(negedge clk);
            core_done   = 1'b0;
            core_result = $urandom;
            core_flag   = 3'($urandom);
            if (core_start && !reset) begin
                if (core_q.size() == 0) begin
                    checkOutput("core_start_unexpected", 32'(core_start), 32'd0);
                    done_timer = -1;
                end else begin
                    cur = core_q.pop_front();
                    checkOutput("core_op", 32'(core_op), 32'(cur.op));
                    checkOutput("core_a", core_a, cur.a);
                    checkOutput("core_b", core_b, cur.b);
                    checkOutput("busy_in_start", 32'(busy), 32'd1);
                    checkOutput("busy_waddr", 32'(busy_waddr), 32'(cur.waddr));
                    done_timer = cur.lat;
                end
            end
            if (done_timer == 0) begin
                core_done   = 1'b1;
                core_result = cur.res;
                core_flag   = cur.flag;
                done_timer  = -1;
            end else if (done_timer > 0) begin
                done_timer--;
            end
        end
    end

    // Monitor: every write-back beat must match the oldest prediction.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (wb_q.size() == 0) begin
                    checkOutput("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    checkOutput("wb_data", wb_data, e.data);
                    checkOutput("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
                    checkOutput("wb_regwrite", 32'(wb_regwrite), 32'(e.regwrite));
                    checkOutput("op_count", 32'(op_count), 32'(e.opc));
                    checkOutput("special_count", 32'(special_count), 32'(e.spc));
                    checkOutput("err_timeout", 32'(err_timeout), 32'(e.err));
                    checkOutput("stall_in_done", 32'(stall), 32'd0);
                end
            end else begin
                checkOutput("wb_regwrite_idle", 32'(wb_regwrite), 32'd0);
            end
        end
    end

    // Overall time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic idleCycle();
        @(negedge clk);
        issue_valid = 1'b0;
        issue_fp    = 1'($urandom);
        issue_op    = 4'($urandom);
        issue_a     = $urandom;
        issue_b     = $urandom;
        issue_waddr = 6'($urandom);
    endtask

    // Present one instruction, play out its stall, and predict its beat.
    // lat is the core latency in cycles after start; < 0 means no completion.
    task automatic applyStimulus(input logic fp, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [5:0] waddr, input logic rw,
                                 input int lat, input logic [31:0] res, input logic [2:0] flag);
        core_beh_t beh;
        wb_exp_t   e;
        logic      aborted;
        int        exp_stall;
        int        cycles;
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_fp       = fp;
        issue_op       = op;
        issue_a        = a;
        issue_b        = b;
        issue_waddr    = waddr;
        issue_regwrite = rw;
        if (!fp) begin
            #1;
            checkOutput("stall_nonfp", 32'(stall), 32'd0);
        end else begin
            aborted = (lat < 0) || (lat > TIMEOUT_CYCLES);
            model_ops++;
            if (!aborted && flag != 3'b000 && model_special < CNT_MOD - 1) model_special++;
            if (aborted) model_err = 1'b1;
            e.data     = aborted ? 32'd0 : res;
            e.waddr    = waddr;
            e.regwrite = rw && (flag == 3'b000) && !aborted;
            e.opc      = CNT_W'(model_ops % CNT_MOD);
            e.spc      = CNT_W'(model_special);
            e.err      = model_err;
            wb_q.push_back(e);
            beh.op = op; beh.a = a; beh.b = b; beh.waddr = waddr;
            beh.lat = lat; beh.res = res; beh.flag = flag;
            core_q.push_back(beh);
            exp_stall = aborted ? TIMEOUT_CYCLES + 2 : lat + 2;
            #1;
            cycles = 0;
            while (stall === 1'b1 && cycles < 200) begin
                cycles++;
                @(negedge clk);
                #1;
            end
            checkOutput("stall_cycles", 32'(cycles), 32'(exp_stall));
        end
    endtask

    // Reset in the middle of WAIT: everything clears and the late completion
    // from the abandoned op must not produce a write-back.
    task automatic resetMidWait();
        core_beh_t beh;
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_fp       = 1'b1;
        issue_op       = 4'h5;
        issue_a        = 32'h1234_5678;
        issue_b        = 32'h9ABC_DEF0;
        issue_waddr    = 6'd50;
        issue_regwrite = 1'b1;
        beh.op = 4'h5; beh.a = 32'h1234_5678; beh.b = 32'h9ABC_DEF0; beh.waddr = 6'd50;
        beh.lat = 12; beh.res = 32'hDEAD_BEEF; beh.flag = 3'b000;
        core_q.push_back(beh);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("busy_before_reset", 32'(busy), 32'd1);
        @(negedge clk);
        reset       = 1'b1;
        issue_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_ops     = 0;
        model_special = 0;
        model_err     = 1'b0;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_core_start", 32'(core_start), 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        checkOutput("rst_special_count", 32'(special_count), 32'd0);
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
        repeat (15) idleCycle();
        #1;
        checkOutput("busy_after_stray_done", 32'(busy), 32'd0);
    endtask

    // Main sequence: reset checks, directed cases, then randomized traffic.
    initial begin
        int r;
        int lat;
        reset          = 1'b1;
        issue_valid    = 1'b0;
        issue_fp       = 1'b0;
        issue_op       = '0;
        issue_a        = '0;
        issue_b        = '0;
        issue_waddr    = '0;
        issue_regwrite = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_core_start", 32'(core_start), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_core_a", core_a, 32'd0);
        checkOutput("reset_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        reset = 1'b0;

        applyStimulus(1'b1, 4'b0010, 32'h3F80_0000, 32'h4000_0000, 6'd33, 1'b1, 3, 32'h4040_0000, 3'b000);
        applyStimulus(1'b1, 4'b0010, 32'h3F80_0000, 32'h4000_0000, 6'd34, 1'b1, 3, 32'h7FC0_0000, 3'b010);
        idleCycle();
        applyStimulus(1'b1, 4'b0011, 32'h4110_0000, 32'h0000_0000, 6'd35, 1'b1, -1, 32'd0, 3'b000);
        applyStimulus(1'b1, 4'b0001, 32'h4000_0000, 32'h4000_0000, 6'd36, 1'b1, 2, 32'h4080_0000, 3'b000);
        applyStimulus(1'b0, 4'b0001, 32'h1, 32'h2, 6'd5, 1'b1, 0, 32'd0, 3'b000);
        applyStimulus(1'b0, 4'b0111, 32'h3, 32'h4, 6'd6, 1'b1, 0, 32'd0, 3'b000);
        applyStimulus(1'b1, 4'b0100, 32'h4040_0000, 32'h3F80_0000, 6'd37, 1'b1, 0, 32'h4000_0000, 3'b000);
        applyStimulus(1'b1, 4'b0101, 32'hAAAA_5555, 32'h5555_AAAA, 6'd38, 1'b1, TIMEOUT_CYCLES, 32'h1111_2222, 3'b000);
        applyStimulus(1'b1, 4'b0110, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 6'd39, 1'b1, TIMEOUT_CYCLES - 1, 32'h3333_4444, 3'b000);
        applyStimulus(1'b1, 4'b0110, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 6'd40, 1'b1, TIMEOUT_CYCLES + 1, 32'h5555_6666, 3'b000);
        resetMidWait();
        applyStimulus(1'b1, 4'b1000, 32'h1, 32'h2, 6'd41, 1'b1, 0, 32'h0000_0003, 3'b000);
        applyStimulus(1'b1, 4'b1001, 32'h4, 32'h5, 6'd42, 1'b0, 1, 32'h0000_0009, 3'b000);

        for (int i = 0; i < 120; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                if ($urandom_range(0, 1) == 0) idleCycle();
                else applyStimulus(1'b0, 4'($urandom), $urandom, $urandom, 6'($urandom), 1'($urandom), 0, 32'd0, 3'b000);
            end
            r = $urandom_range(0, 99);
            if (r < 70)      lat = $urandom_range(0, 6);
            else if (r < 85) lat = $urandom_range(7, 20);
            else if (r < 92) lat = $urandom_range(TIMEOUT_CYCLES - 4, TIMEOUT_CYCLES + 2);
            else if (r < 96) lat = -1;
            else             lat = 0;
            applyStimulus(1'b1, 4'($urandom), $urandom, $urandom, 6'(32 + $urandom_range(0, 31)),
                          1'($urandom), lat, $urandom,
                          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
        end

        for (int k = 0; k < 100 && wb_q.size() > 0; k++) idleCycle();
        repeat (3) idleCycle();
        checkOutput("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        checkOutput("core_queue_drained", 32'(core_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
